load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/byte_lane_align.sv | 24 ++
 rtl/load_store_unit.sv | 102 ++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states, latencies and request legality for load_store_unit.
// Byte/half support is compiled in only when LSU_SUBWORD_EN is defined.
package lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;
  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} lsu_state_e;
  localparam int LAT_ERR  = 1;
  localparam int LAT_WORD = 2;
  localparam int LAT_RMW  = 4;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD_EN = 1'b1;
`else
  localparam bit SUBWORD_EN = 1'b0;
`endif
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] lo);
    return size == SIZE_ILL || (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00) ||
           (!SUBWORD_EN && size != SIZE_WORD);
  endfunction
endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: little-endian lane extraction/extension for loads and lane merge for stores.
module byte_lane_align import lsu_pkg::*; (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] mask, wrep;
  always_comb begin
    rbyte = 8'(rdata >> {lane, 3'b000});
    rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = size == SIZE_BYTE ? {{24{sign_ext & rbyte[7]}}, rbyte} :
                size == SIZE_HALF ? {{16{sign_ext & rhalf[15]}}, rhalf} : rdata;
    mask = size == SIZE_BYTE ? 32'h0000_00FF << {lane, 3'b000} :
           size == SIZE_HALF ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : '1;
    wrep = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    merge_data = (rdata & ~mask) | (wrep & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM in front of a synchronous data memory.
// Define LSU_SUBWORD_EN to build byte/half accesses (read-modify-write stores); otherwise they error.
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqSigned,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [31:0]           reqWriteData,
  output logic                  respValid,
  output logic [31:0]           respData,
  output logic                  respError,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memWriteData,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic [31:0]           memReadData
);
  lsu_state_e state_q, state_d;
  logic write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, load_data, store_data;
  logic accept;
  assign accept = reqValid && state_q == IDLE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
  always_comb begin
    write_d  = accept ? reqWrite : write_q;
    signed_d = accept ? reqSigned : signed_q;
    size_d   = accept ? reqSize : size_q;
    addr_d   = accept ? reqAddress : addr_q;
    wdata_d  = accept ? reqWriteData : wdata_q;
    err_d    = accept ? req_error(reqSize, reqAddress[1:0]) : err_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = req_error(reqSize, reqAddress[1:0]) ? RESP :
                                  (reqWrite && reqSize == SIZE_WORD) ? WR : RD;
`ifdef LSU_SUBWORD_EN
      RD:   state_d = write_q ? MRG : RESP;
      MRG:  state_d = WR;
`else
      RD:   state_d = RESP;
`endif
      WR:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
`ifdef LSU_SUBWORD_EN
  logic [31:0] merge_q, merge_d, merge_data;
  byte_lane_align u_align (
    .size(size_q), .sign_ext(signed_q), .lane(addr_q[1:0]), .rdata(memReadData),
    .wdata(wdata_q), .load_data(load_data), .merge_data(merge_data)
  );
  always_comb merge_d = state_q == MRG ? merge_data : merge_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) merge_q <= '0;
    else merge_q <= merge_d;
  end
  assign store_data = size_q == SIZE_WORD ? wdata_q : merge_q;
`else
  logic unused_sub;
  assign unused_sub = ^{size_q, signed_q};
  assign load_data  = memReadData;
  assign store_data = wdata_q;
`endif
  // All outputs decode from registered state, so the async reset clears them at once.
  always_comb begin
    reqReady     = state_q == IDLE;
    memRead      = state_q == RD;
    memWrite     = state_q == WR;
    respValid    = state_q == RESP;
    respError    = respValid && err_q;
    respData     = (respValid && !err_q && !write_q) ? load_data : '0;
    memAddress   = addr_q & ~ADDR_WIDTH'(3);
    memWriteData = memWrite ? store_data : '0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic checked against a byte-array memory model.
module tb_load_store_unit;
  import lsu_pkg::*;
  localparam logic [31:0] BASE = 32'h7FFF_0000;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b1, reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0] reqSize = 2'b10;
  logic [31:0] reqAddress = '0, reqWriteData = '0;
  logic reqReady, respValid, respError, memRead, memWrite;
  logic [31:0] respData, memAddress, memWriteData, memReadData;
  logic [31:0] dmem [0:15];
  logic [31:0] rdata;
  logic mem_init = 1'b1;
  logic [7:0] rmem [0:63];
  int n_cmp, n_mis, rw_conflict, resp_cnt;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .respValid(respValid), .respData(respData), .respError(respError), .memAddress(memAddress),
    .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'(32'h9E37_79B9 * (i + 1)) ^ 32'h0F1E_2D3C;
  endfunction

  always @(posedge clock) begin
    if (mem_init) for (int i = 0; i < 16; i++) dmem[i] <= pat(i);
    else if (memWrite) dmem[memAddress[5:2]] <= memWriteData;
    if (memRead) rdata <= dmem[memAddress[5:2]];
  end
  assign memReadData = rdata;

  always @(negedge clock) begin
    if (memRead && memWrite) rw_conflict++;
    if (respValid) resp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int off);
    int b;
    b = off & ~3;
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction

  function automatic void model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] d);
    int nb, off;
    nb  = sz == SIZE_BYTE ? 1 : sz == SIZE_HALF ? 2 : 4;
    off = int'(a - BASE);
    err = sz == SIZE_ILL || (off % nb) != 0 || (!SUB && nb != 4);
    d = '0;
    if (err) return;
    if (w) for (int i = 0; i < nb; i++) rmem[off+i] = wd[8*i +: 8];
    else begin
      for (int i = 0; i < nb; i++) d = d | ({24'b0, rmem[off+i]} << (8*i));
      if (sg && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    bit ee, sub_st;
    logic [31:0] ed;
    int lat, nrd, nwr, wr_at, elat;
    model(w, sz, sg, a, wd, ee, ed);
    sub_st = w && sz != SIZE_WORD;
    elat = ee ? LAT_ERR : sub_st ? LAT_RMW : LAT_WORD;
    @(negedge clock);
    check("ready", reqReady, 1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddress = a; reqWriteData = wd;
    @(posedge clock);
    #1 reqValid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wr_at = 0;
    while (lat < 8) begin
      @(negedge clock);
      lat++;
      if (memRead) nrd++;
      if (memWrite) begin
        nwr++;
        wr_at = lat;
        check("wdata", memWriteData, word_at(int'(a - BASE)));
      end
      if (lat == 1 && !ee) check("maddr", memAddress, a & ~32'h3);
      if (respValid) break;
    end
    rd = respData;
    check("latency", lat, elat);
    check("error", respError, ee);
    check("data", respData, ed);
    check("reads", nrd, (ee || (w && !sub_st)) ? 0 : 1);
    check("writes", nwr, (!ee && w) ? 1 : 0);
    check("wr_cycle", wr_at, (!ee && w) ? elat - 1 : 0);
  endtask

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 64; i++) rmem[i] = 8'(pat(i / 4) >> (8 * (i % 4)));
    #1 reset_n = 1'b0;
    #1;
    check("rst_respValid", respValid, 0);
    check("rst_respError", respError, 0);
    check("rst_respData", respData, 0);
    check("rst_memRead", memRead, 0);
    check("rst_memWrite", memWrite, 0);
    check("rst_memAddress", memAddress, 0);
    check("rst_memWriteData", memWriteData, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    mem_init = 1'b0;
    reset_n = 1'b1;
    #1 check("rst_ready", reqReady, 1);

    do_req(1, SIZE_WORD, 0, 32'h7FFF_0010, 32'hDEAD_BEEF, rd);
    do_req(0, SIZE_WORD, 0, 32'h7FFF_0010, 0, rd);
    check("word_rt", rd, 32'hDEAD_BEEF);
    do_req(1, SIZE_WORD, 0, 32'h7FFF_0020, 32'h1122_3344, rd);
    do_req(1, SIZE_BYTE, 0, 32'h7FFF_0022, 32'h0000_00AA, rd);
    do_req(0, SIZE_WORD, 0, 32'h7FFF_0020, 0, rd);
    check("byte_merge", rd, SUB ? 32'h11AA_3344 : 32'h1122_3344);
    do_req(1, SIZE_WORD, 0, 32'h7FFF_0020, 32'h80FF_7F01, rd);
    do_req(0, SIZE_BYTE, 1, 32'h7FFF_0022, 0, rd);
    check("sbyte_load", rd, SUB ? 32'hFFFF_FFFF : 32'h0);
    do_req(0, SIZE_HALF, 0, 32'h7FFF_0022, 0, rd);
    check("uhalf_load", rd, SUB ? 32'h0000_80FF : 32'h0);
    do_req(0, SIZE_WORD, 0, 32'h7FFF_0002, 0, rd);

    begin : rst_mid
      logic [31:0] a;
      int snap;
      a = 32'h7FFF_0014;
      @(negedge clock);
      snap = resp_cnt;
      reqValid = 1'b1; reqWrite = SUB; reqSize = SUB ? SIZE_BYTE : SIZE_WORD; reqSigned = 1'b0;
      reqAddress = SUB ? a + 1 : a; reqWriteData = 32'h0000_0055;
      @(posedge clock);
      #1 reqValid = 1'b0;
      repeat (SUB ? 2 : 1) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("mid_memRead", memRead, 0);
      check("mid_memWrite", memWrite, 0);
      check("mid_respValid", respValid, 0);
      check("mid_respError", respError, 0);
      check("mid_respData", respData, 0);
      check("mid_memAddress", memAddress, 0);
      check("mid_memWriteData", memWriteData, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("mid_no_resp", resp_cnt - snap, 0);
      do_req(0, SIZE_WORD, 0, a, 0, rd);
    end

    begin : burst
      int acc, nresp;
      bit ee;
      logic [31:0] ed;
      acc = 0; nresp = 0;
      model(0, SIZE_WORD, 0, 32'h7FFF_0010, 0, ee, ed);
      @(negedge clock);
      reqValid = 1'b1; reqWrite = 1'b0; reqSize = SIZE_WORD; reqSigned = 1'b0; reqAddress = 32'h7FFF_0010;
      for (int i = 0; i < 30; i++) begin
        if (reqReady) acc++;
        if (respValid) begin
          nresp++;
          check("burst_data", respData, ed);
        end
        @(negedge clock);
      end
      reqValid = 1'b0;
      check("burst_accepts", acc, 30 / (LAT_WORD + 1));
      check("burst_resps", nresp, acc);
    end

    repeat (300) begin
      logic [1:0] sz;
      int off;
      sz  = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) off = sz == SIZE_HALF ? off & ~1 : (sz == SIZE_WORD || sz == SIZE_ILL) ? off & ~3 : off;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), BASE + 32'(off), $urandom, rd);
    end

    check("rw_exclusive", rw_conflict, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
